branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Dynamic branch predictor for the 5-stage pipeline: 2-bit saturating BHT plus a tagged BTB.
//  Predicts taken/target for the IF-stage PC and resolves branches in EX.
//  Drives BEQ_WRONG_PRED and the redirect PC consumed by the hazard unit and the PC mux.
//  Keeps registered branch/mispredict statistics for debug.
// PARAMETERS
//  IDX_BITS  4   log2 of table entries (16); index = PC[IDX_BITS+1:2]
//  CNT_W     16  width of statistics counters
// PORTS
//  CLK            in   1         clock, all state updates on rising edge
//  RST_N          in   1         asynchronous active-low reset
//  PC_IF          in   32        PC of instruction being fetched
//  PRED_TAKEN_IF  out  1         prediction for PC_IF: 1 = taken
//  PRED_TARGET_IF out  32        next-PC prediction for PC_IF
//  STALL          in   1         pipeline freeze; blocks table/stat updates
//  BR_VALID_EX    in   1         conditional branch resolving in EX this cycle
//  PC_EX          in   32        PC of branch in EX
//  BR_TAKEN_EX    in   1         actual outcome
//  BR_TARGET_EX   in   32        actual taken target
//  PRED_TAKEN_EX  in   1         prediction carried down from IF with the branch
//  PRED_TARGET_EX in   32        predicted next PC carried down from IF
//  BEQ_WRONG_PRED out  1         misprediction in EX (combinational)
//  REDIRECT_PC    out  32        correct next PC when BEQ_WRONG_PRED = 1
//  BR_COUNT       out  CNT_W     resolved branches (registered, saturating)
//  MISPRED_COUNT  out  CNT_W     mispredictions (registered, saturating)
// BEHAVIOUR
//  - Per entry: VALID, TAG = PC[31:IDX_BITS+2], TARGET[31:0], CTR[1:0].
//  - Reset (async, RST_N=0): all VALID=0, all CTR=2'b01, BR_COUNT=MISPRED_COUNT=0.
//    Combinational outputs then read: PRED_TAKEN_IF=0, PRED_TARGET_IF=PC_IF+4.
//  - Lookup (0-cycle, combinational): HIT = VALID[i] && TAG[i]==PC_IF tag.
//    PRED_TAKEN_IF = HIT && CTR[i][1]; PRED_TARGET_IF = PRED_TAKEN_IF ? TARGET[i] : PC_IF+4.
//  - Resolve (combinational): BEQ_WRONG_PRED = BR_VALID_EX &&
//    ((PRED_TAKEN_EX != BR_TAKEN_EX) || (BR_TAKEN_EX && PRED_TARGET_EX != BR_TARGET_EX)).
//    REDIRECT_PC = BR_TAKEN_EX ? BR_TARGET_EX : PC_EX+4. Asserted regardless of STALL.
//  - Update (rising edge, only when BR_VALID_EX && !STALL), entry j = PC_EX index:
//    * tag hit: CTR saturating +1 if taken (max 2'b11), -1 if not (min 2'b00);
//      if taken, TARGET<=BR_TARGET_EX.
//    * tag miss/invalid, taken: allocate VALID=1, TAG, TARGET, CTR=2'b10.
//    * tag miss/invalid, not taken: no allocation, table unchanged.
//    * BR_COUNT+1; MISPRED_COUNT+1 if BEQ_WRONG_PRED; both saturate at all-ones.
//  - Read/write same index in same cycle: IF lookup sees pre-update contents (write takes
//    effect next cycle); no bypass.
//  - STALL=1: no table or counter change, lookups continue.
//  - Reset mid-operation: state cleared immediately, no partial update completes.
//  - PC arithmetic: PC+4 wraps modulo 2^32; PC[1:0] ignored.
// TESTING
//  1 Reset, PC_IF=0x100 -> PRED_TAKEN_IF=0, PRED_TARGET_IF=0x104, counters 0.
//  2 Resolve taken at PC_EX=0x100 tgt 0x80, PRED_TAKEN_EX=0 -> BEQ_WRONG_PRED=1,
//    REDIRECT_PC=0x80; next cycle PC_IF=0x100 -> taken, target 0x80, MISPRED_COUNT=1.
//  3 Same branch 2x not-taken -> CTR 2'b10->01->00; lookup not taken; 3rd not-taken
//    with PRED_TAKEN_EX=0 -> no mispredict, CTR stays 00.
//  4 Alias: PC 0x140 (same index, diff tag, IDX_BITS=4) after 0x100 entry -> miss, not
//    taken; taken 0x140 resolve replaces entry, 0x100 now misses.
//  5 BR_VALID_EX=1 with STALL=1 -> BEQ_WRONG_PRED still valid, table and counters unchanged.
//  6 Force BR_COUNT=all-ones-1 via 2^16 resolves (or CNT_W=4 override) -> saturates,
//    no wrap; assert RST_N low mid-run -> all cleared asynchronously before next edge.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for a 5-stage pipeline. It combines a direct-mapped
// table of 2-bit saturating counters with a tagged branch target buffer.
//
// The IF stage gets a zero-cycle prediction for PC_IF. The EX stage resolves
// the branch against the prediction that travelled down with it.
// BEQ_WRONG_PRED and REDIRECT_PC feed the hazard unit and the PC mux.
// Saturating statistics counters record resolved branches and mispredictions
// for debug.
//
// Parameters
//   IDX_BITS  log2 of the number of table entries; index = PC[IDX_BITS+1:2]
//   CNT_W     width of the statistics counters
//
// Ports
//   CLK             in   1      clock; all state changes on the rising edge
//   RST_N           in   1      asynchronous active-low reset
//   PC_IF           in   32     PC being fetched
//   PRED_TAKEN_IF   out  1      prediction for PC_IF (1 = taken)
//   PRED_TARGET_IF  out  32     predicted next PC for PC_IF
//   STALL           in   1      pipeline freeze; blocks table/stat updates
//   BR_VALID_EX     in   1      conditional branch resolving in EX
//   PC_EX           in   32     PC of the resolving branch
//   BR_TAKEN_EX     in   1      actual outcome
//   BR_TARGET_EX    in   32     actual taken target
//   PRED_TAKEN_EX   in   1      prediction carried down from IF
//   PRED_TARGET_EX  in   32     predicted next PC carried down from IF
//   BEQ_WRONG_PRED  out  1      misprediction in EX (combinational)
//   REDIRECT_PC     out  32     correct next PC when BEQ_WRONG_PRED = 1
//   BR_COUNT        out  CNT_W  resolved branches (registered, saturating)
//   MISPRED_COUNT   out  CNT_W  mispredictions (registered, saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int IDX_BITS = 4,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      PC_IF,
    output logic             PRED_TAKEN_IF,
    output logic [31:0]      PRED_TARGET_IF,
    input  logic             STALL,
    input  logic             BR_VALID_EX,
    input  logic [31:0]      PC_EX,
    input  logic             BR_TAKEN_EX,
    input  logic [31:0]      BR_TARGET_EX,
    input  logic             PRED_TAKEN_EX,
    input  logic [31:0]      PRED_TARGET_EX,
    output logic             BEQ_WRONG_PRED,
    output logic [31:0]      REDIRECT_PC,
    output logic [CNT_W-1:0] BR_COUNT,
    output logic [CNT_W-1:0] MISPRED_COUNT
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;

    localparam logic [1:0]       CTR_RESET = 2'b01;  // weakly not-taken
    localparam logic [1:0]       CTR_ALLOC = 2'b10;  // weakly taken
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------
    function automatic logic [IDX_BITS-1:0] idx_of(input logic [31:0] pc);
        return pc[IDX_BITS+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] pc);
        return pc[31:IDX_BITS+2];
    endfunction

    // 2-bit saturating counter step: up on taken, down on not-taken.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_ONE;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                valid_q  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [CNT_W-1:0]    br_cnt_q;
    logic [CNT_W-1:0]    mis_cnt_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [IDX_BITS-1:0] if_idx_s;
    logic [TAG_W-1:0]    if_tag_s;
    logic                if_hit_s;
    logic [31:0]         if_pc_plus4_s;
    logic                pred_taken_s;
    logic [31:0]         pred_target_s;

    logic [IDX_BITS-1:0] ex_idx_s;
    logic [TAG_W-1:0]    ex_tag_s;
    logic                ex_hit_s;
    logic [31:0]         ex_pc_plus4_s;
    logic                wrong_pred_s;
    logic [31:0]         redirect_s;

    logic                upd_en_s;
    logic                wr_en_s;
    logic                wr_valid_d;
    logic [TAG_W-1:0]    wr_tag_d;
    logic [31:0]         wr_target_d;
    logic [1:0]          wr_ctr_d;
    logic [CNT_W-1:0]    br_cnt_d;
    logic [CNT_W-1:0]    mis_cnt_d;

    // Word-alignment bits never affect indexing or tags.
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{PC_IF[1:0], PC_EX[1:0]};

    // IF lookup: read the table at PC_IF and form the taken/target prediction.
    always_comb begin
        if_idx_s      = idx_of(PC_IF);
        if_tag_s      = tag_of(PC_IF);
        if_pc_plus4_s = PC_IF + 32'd4;
        if_hit_s      = valid_q[if_idx_s] && (tag_q[if_idx_s] == if_tag_s);
        pred_taken_s  = if_hit_s && ctr_q[if_idx_s][1];
        if (pred_taken_s) begin
            pred_target_s = target_q[if_idx_s];
        end else begin
            pred_target_s = if_pc_plus4_s;
        end
    end

    // EX resolve: detect a misprediction and pick the corrected next PC.
    // This path ignores STALL, so the redirect is seen even while frozen.
    always_comb begin
        ex_pc_plus4_s = PC_EX + 32'd4;
        wrong_pred_s  = BR_VALID_EX &&
                        ((PRED_TAKEN_EX != BR_TAKEN_EX) ||
                         (BR_TAKEN_EX && (PRED_TARGET_EX != BR_TARGET_EX)));
        if (BR_TAKEN_EX) begin
            redirect_s = BR_TARGET_EX;
        end else begin
            redirect_s = ex_pc_plus4_s;
        end
    end

    // Next-state of the table entry addressed by PC_EX and the statistics counters.
    always_comb begin
        ex_idx_s    = idx_of(PC_EX);
        ex_tag_s    = tag_of(PC_EX);
        ex_hit_s    = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_tag_s);
        upd_en_s    = BR_VALID_EX && !STALL;

        wr_en_s     = 1'b0;
        wr_valid_d  = valid_q[ex_idx_s];
        wr_tag_d    = tag_q[ex_idx_s];
        wr_target_d = target_q[ex_idx_s];
        wr_ctr_d    = ctr_q[ex_idx_s];
        br_cnt_d    = br_cnt_q;
        mis_cnt_d   = mis_cnt_q;

        if (upd_en_s) begin
            br_cnt_d = cnt_sat_inc(br_cnt_q);
            if (wrong_pred_s) begin
                mis_cnt_d = cnt_sat_inc(mis_cnt_q);
            end else begin
                mis_cnt_d = mis_cnt_q;
            end

            if (ex_hit_s) begin
                // Train the existing entry; its target is refreshed only by a taken branch.
                wr_en_s  = 1'b1;
                wr_ctr_d = ctr_step(ctr_q[ex_idx_s], BR_TAKEN_EX);
                if (BR_TAKEN_EX) begin
                    wr_target_d = BR_TARGET_EX;
                end else begin
                    wr_target_d = target_q[ex_idx_s];
                end
            end else if (BR_TAKEN_EX) begin
                // Allocate over whatever lived at this index (an alias or an empty slot).
                wr_en_s     = 1'b1;
                wr_valid_d  = 1'b1;
                wr_tag_d    = ex_tag_s;
                wr_target_d = BR_TARGET_EX;
                wr_ctr_d    = CTR_ALLOC;
            end else begin
                // A not-taken miss would only ever predict fall-through, so nothing is allocated.
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table storage: cleared asynchronously, written at one index per cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < ENTRIES; k++) begin
                valid_q[k]  <= 1'b0;
                tag_q[k]    <= {TAG_W{1'b0}};
                target_q[k] <= 32'd0;
                ctr_q[k]    <= CTR_RESET;
            end
        end else if (wr_en_s) begin
            valid_q[ex_idx_s]  <= wr_valid_d;
            tag_q[ex_idx_s]    <= wr_tag_d;
            target_q[ex_idx_s] <= wr_target_d;
            ctr_q[ex_idx_s]    <= wr_ctr_d;
        end
    end

    // Statistics counters.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            br_cnt_q  <= {CNT_W{1'b0}};
            mis_cnt_q <= {CNT_W{1'b0}};
        end else begin
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    assign PRED_TAKEN_IF  = pred_taken_s;
    assign PRED_TARGET_IF = pred_target_s;
    assign BEQ_WRONG_PRED = wrong_pred_s;
    assign REDIRECT_PC    = redirect_s;
    assign BR_COUNT       = br_cnt_q;
    assign MISPRED_COUNT  = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int TB_CNT_W = 4;

    logic                CLK = 1'b0;
    logic                RST_N;
    logic [31:0]         PC_IF;
    logic                PRED_TAKEN_IF;
    logic [31:0]         PRED_TARGET_IF;
    logic                STALL;
    logic                BR_VALID_EX;
    logic [31:0]         PC_EX;
    logic                BR_TAKEN_EX;
    logic [31:0]         BR_TARGET_EX;
    logic                PRED_TAKEN_EX;
    logic [31:0]         PRED_TARGET_EX;
    logic                BEQ_WRONG_PRED;
    logic [31:0]         REDIRECT_PC;
    logic [TB_CNT_W-1:0] BR_COUNT;
    logic [TB_CNT_W-1:0] MISPRED_COUNT;

    branch_predictor #(.IDX_BITS(4), .CNT_W(TB_CNT_W)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .PC_IF          (PC_IF),
        .PRED_TAKEN_IF  (PRED_TAKEN_IF),
        .PRED_TARGET_IF (PRED_TARGET_IF),
        .STALL          (STALL),
        .BR_VALID_EX    (BR_VALID_EX),
        .PC_EX          (PC_EX),
        .BR_TAKEN_EX    (BR_TAKEN_EX),
        .BR_TARGET_EX   (BR_TARGET_EX),
        .PRED_TAKEN_EX  (PRED_TAKEN_EX),
        .PRED_TARGET_EX (PRED_TARGET_EX),
        .BEQ_WRONG_PRED (BEQ_WRONG_PRED),
        .REDIRECT_PC    (REDIRECT_PC),
        .BR_COUNT       (BR_COUNT),
        .MISPRED_COUNT  (MISPRED_COUNT)
    );

    always #5 CLK = ~CLK;

    // Which DUT output an expectation refers to.
    localparam int S_PTK = 0;
    localparam int S_PTG = 1;
    localparam int S_WRG = 2;
    localparam int S_RDR = 3;
    localparam int S_BRC = 4;
    localparam int S_MPC = 5;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] observe(input int sel);
        logic [31:0] v;
        case (sel)
            S_PTK:   v = {31'd0, PRED_TAKEN_IF};
            S_PTG:   v = PRED_TARGET_IF;
            S_WRG:   v = {31'd0, BEQ_WRONG_PRED};
            S_RDR:   v = REDIRECT_PC;
            S_BRC:   v = 32'(BR_COUNT);
            S_MPC:   v = 32'(MISPRED_COUNT);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    // Monitor: drains the scoreboard on the falling edge, away from updates.
    exp_t        cur;
    logic [31:0] obs;
    always @(negedge CLK) begin
        while (sb_q.size() != 0) begin
            cur = sb_q.pop_front();
            obs = observe(cur.sel);
            n_vec++;
            if (obs !== cur.exp) begin
                n_err++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", cur.name, obs, cur.exp);
            end
        end
    end

    task automatic expect_out(input string nm, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic drv(input logic [31:0] pcif, input logic bv, input logic [31:0] pcex,
                       input logic tk, input logic [31:0] tgt, input logic pt,
                       input logic [31:0] ptg, input logic st);
        PC_IF          = pcif;
        BR_VALID_EX    = bv;
        PC_EX          = pcex;
        BR_TAKEN_EX    = tk;
        BR_TARGET_EX   = tgt;
        PRED_TAKEN_EX  = pt;
        PRED_TARGET_EX = ptg;
        STALL          = st;
    endtask

    task automatic lookup_chk(input string nm, input logic tk, input logic [31:0] tg);
        expect_out({nm, "_ptk"}, S_PTK, {31'd0, tk});
        expect_out({nm, "_ptg"}, S_PTG, tg);
    endtask

    task automatic resolve_chk(input string nm, input logic w, input logic [31:0] r);
        expect_out({nm, "_wrg"}, S_WRG, {31'd0, w});
        expect_out({nm, "_rdr"}, S_RDR, r);
    endtask

    task automatic count_chk(input string nm, input int b, input int m);
        expect_out({nm, "_brc"}, S_BRC, 32'(b));
        expect_out({nm, "_mpc"}, S_MPC, 32'(m));
    endtask

    // Let the monitor sample at the falling edge, then move past the next rising edge.
    task automatic step();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 1'b0;
        drv(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup_chk("rst", 1'b0, 32'h104);
        count_chk("rst", 0, 0);
        step();
        RST_N = 1'b1;

        // Taken branch, predicted not-taken: mispredict; lookup still sees old table.
        drv(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104, 1'b0);
        resolve_chk("alloc", 1'b1, 32'h80);
        lookup_chk("alloc_pre", 1'b0, 32'h104);
        step();

        drv(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup_chk("alloc_post", 1'b1, 32'h80);
        count_chk("alloc_post", 1, 1);
        step();

        // Not-taken while predicted taken: CTR 10 -> 01.
        drv(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 1'b0);
        resolve_chk("nt1", 1'b1, 32'h104);
        step();

        // CTR 01: predicts not taken; correct not-taken resolve, CTR -> 00.
        drv(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0);
        lookup_chk("nt2", 1'b0, 32'h104);
        resolve_chk("nt2", 1'b0, 32'h104);
        count_chk("nt2", 2, 2);
        step();

        // Third not-taken: CTR stays 00.
        drv(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b0, 32'h104, 1'b0);
        lookup_chk("nt3", 1'b0, 32'h104);
        resolve_chk("nt3", 1'b0, 32'h104);
        count_chk("nt3", 3, 2);
        step();

        // Taken from 00 -> 01: still predicts not taken next; target refreshed to 0x200.
        drv(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0);
        resolve_chk("up1", 1'b1, 32'h200);
        count_chk("up1", 4, 2);
        step();

        drv(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0);
        lookup_chk("up2", 1'b0, 32'h104);
        count_chk("up2", 5, 3);
        step();

        // CTR 10: taken to 0x200. Resolve with the wrong target is a mispredict.
        drv(32'h100, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0);
        lookup_chk("tgt", 1'b1, 32'h200);
        resolve_chk("tgt", 1'b1, 32'h300);
        step();

        drv(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup_chk("tgt_post", 1'b1, 32'h300);
        count_chk("tgt_post", 7, 5);
        step();

        // Alias 0x140 shares index 0: misses, then replaces the 0x100 entry.
        drv(32'h140, 1'b1, 32'h140, 1'b1, 32'h40, 1'b0, 32'h144, 1'b0);
        lookup_chk("alias_pre", 1'b0, 32'h144);
        resolve_chk("alias", 1'b1, 32'h40);
        step();

        drv(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup_chk("alias_old", 1'b0, 32'h104);
        count_chk("alias", 8, 6);
        step();

        // Stalled resolve: outputs valid but nothing updates.
        drv(32'h140, 1'b1, 32'h140, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1);
        lookup_chk("stall", 1'b1, 32'h40);
        resolve_chk("stall", 1'b1, 32'h144);
        step();

        drv(32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup_chk("stall_post", 1'b1, 32'h40);
        count_chk("stall_post", 8, 6);
        step();

        // Not-taken miss: counted, no allocation.
        drv(32'h208, 1'b1, 32'h208, 1'b0, 32'h999, 1'b0, 32'h20C, 1'b0);
        resolve_chk("ntmiss", 1'b0, 32'h20C);
        step();

        drv(32'h208, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup_chk("ntmiss_post", 1'b0, 32'h20C);
        count_chk("ntmiss_post", 9, 6);
        step();

        // PC+4 wraps at the top of the address space.
        drv(32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup_chk("wrap", 1'b0, 32'h0);
        resolve_chk("wrap", 1'b0, 32'h0);
        step();

        // Drive the 4-bit counters into saturation with mispredicted taken branches.
        for (int i = 0; i < 8; i++) begin
            drv(32'h0, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304, 1'b0);
            step();
        end
        drv(32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        count_chk("sat_br", 15, 14);
        step();
        for (int i = 0; i < 2; i++) begin
            drv(32'h0, 1'b1, 32'h300, 1'b1, 32'h500, 1'b0, 32'h304, 1'b0);
            step();
        end
        drv(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        count_chk("sat_both", 15, 15);
        lookup_chk("sat_tbl", 1'b1, 32'h500);
        step();

        // Asynchronous reset mid-run, with a branch pending: cleared before the next edge.
        drv(32'h300, 1'b1, 32'h300, 1'b1, 32'h600, 1'b0, 32'h304, 1'b0);
        RST_N = 1'b0;
        lookup_chk("arst", 1'b0, 32'h304);
        count_chk("arst", 0, 0);
        step();
        RST_N = 1'b1;
        drv(32'h300, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        lookup_chk("arst_post", 1'b0, 32'h304);
        count_chk("arst_post", 0, 0);
        step();

        // Bounded drain of anything the monitor has not yet consumed.
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) begin
            @(negedge CLK);
        end
        #1;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0 pending", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
